// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down modulo counter.
package counter_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // Limits a load value to the top of the count range.
    function automatic logic [31:0] cnt_clamp(input logic [31:0] val, input logic [31:0] modulus);
        return (val > (modulus - 32'd1)) ? (modulus - 32'd1) : val;
    endfunction

endpackage

// File: rtl/counter_nbit_updown_if.sv
// Control and status bundle of the up/down modulo counter.
interface counter_nbit_updown_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, clear, load, load_val, ovf_clr,
        input  q, tc, ovf
    );

    modport slave (
        input  en, up, clear, load, load_val, ovf_clr,
        output q, tc, ovf
    );
endinterface

// File: rtl/counter_prescaler.sv
// Enable divider: tick goes high on every PRESCALE-th enabled cycle.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int unsigned   CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/counter_nbit_updown.sv
// Up/down modulo counter with prescale, wrap/saturate bounds, terminal-count pulse
// and sticky overflow flag.
module counter_nbit_updown
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned PRESCALE = 1,
    parameter bit          SATURATE = CNT_WRAP
) (
    input logic                  clk,
    input logic                  rst,
    counter_nbit_updown_if.slave bus
);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             bound;

    generate
        if (PRESCALE == 1) begin : g_no_prescale
            assign tick = bus.en;
        end else begin : g_prescale
            counter_prescaler #(
                .PRESCALE (PRESCALE)
            ) u_prescaler (
                .clk      (clk),
                .rst      (rst),
                .en       (bus.en),
                .sync_clr (bus.clear | bus.load),
                .tick     (tick)
            );
        end
    endgenerate

    // Bounds are compared explicitly so a non-power-of-2 modulus wraps exactly.
    always_comb begin
        q_d   = q_q;
        bound = 1'b0;
        if (bus.clear) begin
            q_d = '0;
        end else if (bus.load) begin
            q_d = WIDTH'(cnt_clamp(32'(bus.load_val), 32'(MODULUS)));
        end else if (tick) begin
            if (bus.up) begin
                if (q_q == Q_MAX) begin
                    bound = 1'b1;
                    q_d   = (SATURATE == CNT_SAT) ? q_q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    bound = 1'b1;
                    q_d   = (SATURATE == CNT_SAT) ? q_q : Q_MAX;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        tc_d  = bound;
        ovf_d = ovf_q;
        if (bound) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q   = q_q;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;
endmodule
